// File: rtl/display_pkg.sv
// Shared definitions for the BCD converter and the display block that consumes its digits.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    localparam int          NUM_DIGITS  = 4;
    localparam int unsigned MAX_DECIMAL = 32'd9999;
    localparam logic [3:0]  ERR_DIGIT   = 4'hF;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the next shift.
module bcd_add3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Correct the digit so the following left shift carries cleanly into the next decade.
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end else begin
            o_digit = i_digit;
        end
    end

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3), one operand bit per clock.
// Build option BCD_CONVERTER_SATURATE_EN clamps operands above 9999 to 9999 instead of showing error digits.
import display_pkg::*;

module bcd_converter #(
    parameter int IN_WIDTH = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [IN_WIDTH-1:0] value,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [3:0]          segment0,
    output logic [3:0]          segment1,
    output logic [3:0]          segment2,
    output logic [3:0]          segment3
);

    localparam int SCR_W = 4 * NUM_DIGITS;

    conv_state_e         r_state;
    conv_state_e         w_next_state;
    logic [IN_WIDTH-1:0] r_operand;
    logic [IN_WIDTH-1:0] w_capture;
    logic [SCR_W-1:0]    r_scratch;
    logic [SCR_W-1:0]    w_adj;
    logic [3:0]          r_count;
    logic                r_ovf;
    logic                r_carry;
    logic                w_last;
    logic                w_too_big;

    assign w_last    = (r_count == 4'(IN_WIDTH - 1));
    assign w_too_big = (32'(value) > MAX_DECIMAL);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_digit (r_scratch[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    // Operand actually fed into the shifter.
    always_comb begin
        w_capture = value;
`ifdef BCD_CONVERTER_SATURATE_EN
        if (w_too_big) begin
            w_capture = IN_WIDTH'(MAX_DECIMAL);
        end else begin
            w_capture = value;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; start is only honoured in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_SHIFT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_operand <= '0;
            r_scratch <= '0;
            r_count   <= 4'd0;
            r_ovf     <= 1'b0;
            r_carry   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            segment0  <= 4'd0;
            segment1  <= 4'd0;
            segment2  <= 4'd0;
            segment3  <= 4'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_operand <= w_capture;
                        r_scratch <= '0;
                        r_count   <= 4'd0;
                        r_ovf     <= w_too_big;
                        r_carry   <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // A bit leaving the top decade means the result cannot fit four digits.
                    r_scratch <= {w_adj[SCR_W-2:0], r_operand[IN_WIDTH-1]};
                    r_operand <= {r_operand[IN_WIDTH-2:0], 1'b0};
                    r_carry   <= r_carry | w_adj[SCR_W-1];
                    r_count   <= w_last ? 4'd0 : (r_count + 4'd1);
                end
                ST_DONE: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    overflow <= r_ovf | r_carry;
`ifdef BCD_CONVERTER_SATURATE_EN
                    segment0 <= r_scratch[3:0];
                    segment1 <= r_scratch[7:4];
                    segment2 <= r_scratch[11:8];
                    segment3 <= r_scratch[15:12];
`else
                    if (r_ovf | r_carry) begin
                        segment0 <= ERR_DIGIT;
                        segment1 <= ERR_DIGIT;
                        segment2 <= ERR_DIGIT;
                        segment3 <= ERR_DIGIT;
                    end else begin
                        segment0 <= r_scratch[3:0];
                        segment1 <= r_scratch[7:4];
                        segment2 <= r_scratch[11:8];
                        segment3 <= r_scratch[15:12];
                    end
`endif
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
